core_seq: RTL and testbench
===========================

# core_seq

Autonomous layer sequencer for the 8x8 weight-stationary core. It replaces testbench-driven instruction streaming by generating the 50-bit instruction word internally. Per kernel position it loads weights, streams activations and drains OFIFO psums into pmem. After the last kernel position it replays pmem through the SFP with accumulate, which closes the pmem-to-SFP path. It sits between a host/testbench start interface and the core datapath instruction port.

## Interface
- row, 8, PE array rows / weight vectors per kernel position
- col, 8, PE array columns
- xmem_aw, 11, xmem address width
- pmem_aw, 14, pmem address width
- n_act, 36, activation vectors per kernel position (= psum vectors per pass)
- n_kij, 9, kernel positions per layer
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- start  in  1  begin layer; sampled only in IDLE
- mode  in  1  PE mode bit, latched on accepted start
- w_base  in  xmem_aw  xmem weight base, latched on start
- x_base  in  xmem_aw  xmem activation base, latched on start
- p_base  in  pmem_aw  pmem psum base, latched on start
- ofifo_valid  in  1  OFIFO holds a full psum vector
- inst  out  50  core instruction word, standard bit map (acc 49, CEN_pmem 48, WEN_pmem 47, A_pmem 46:33, CEN1 32, A1 31:21, CEN0 20, WEN0 19, A0 18:8, ofifo_rd 7, ififo_wr 6, ififo_rd 5, l0_rd 4, l0_wr 3, mode 2, execute 1, load 0)
- busy  out  1  high from the cycle after an accepted start through DONE
- done  out  1  one-cycle pulse in DONE

## Operation
- All outputs are registered.
- Idle inst has CEN/WEN fields high and all other bits 0, giving 0x1_8001_0018_0000.
- The following are always driven to these values: ififo_wr=0, ififo_rd=0, CEN1=1, A1=0. Mode bit = latched mode.
- States: IDLE → W_L0 → W_PE → W_FLUSH → X_L0 → X_EXEC → DRAIN → (next k: W_L0 | k=n_kij-1: ACC) → DONE → IDLE. k counts 0..n_kij-1.
- W_L0, row+1 cycles:
  - In cycle i<row: CEN0=0, WEN0=1, A0=w_base+k·row+i.
  - In cycles 1..row: l0_wr=1, reflecting 1-cycle xmem read latency.
- W_PE, row cycles: l0_rd=1, load=1.
- W_FLUSH, row+col cycles: idle inst.
- X_L0, n_act+1 cycles: same pattern as W_L0 with A0=x_base+k·n_act+i.
- X_EXEC, n_act cycles: l0_rd=1, execute=1.
- DRAIN:
  - In each cycle with ofifo_valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+k·n_act+j, then j++.
  - In cycles with ofifo_valid=0: idle inst (stall).
  - Leave DRAIN after j reaches n_act.
- ACC: for each output o in 0..n_act-1, n_kij+1 cycles:
  - In cycle t<n_kij: CEN_pmem=0, WEN_pmem=1, A_pmem=p_base+t·n_act+o.
  - In cycles 1..n_kij: acc=1.
- DONE, 1 cycle: done=1, idle inst.
- Address arithmetic is modulo 2^aw and wraps silently. Counters are sized with clog2.

## Timing
- Reset, any state: next edge gives state IDLE, inst idle, busy=0, done=0, counters 0. No partial-pass recovery.
- start accepted in IDLE: first W_L0 inst appears on the following edge.
- start while not IDLE, including the DONE cycle: ignored.
- base/mode input changes after acceptance: no effect.
- Minimum per-k length: (row+1)+row+(row+col)+(n_act+1)+n_act+n_act cycles.
- ACC length: n_act·(n_kij+1) cycles.
- ofifo_valid outside DRAIN: ignored.

## Structure
- core_pkg holds:
  - inst bit-position localparams
  - INST_IDLE constant
  - state enum
- Sub-module rd_strobe_dly: 1-cycle delay turning the "read issued" signal into the l0_wr/acc strobe. Instantiated twice: xmem→l0_wr and pmem→acc.

## Test plan
- Reset, with no start issued: inst==0x1_8001_0018_0000, busy=0, done=0 for 20 cycles.
- row=col=8, n_kij=1, n_act=4, w_base=0x10, start → A0=0x10..0x17 on 8 consecutive cycles with CEN0=0; l0_wr high exactly 8 cycles starting one cycle later; load high 8 cycles.
- DRAIN with ofifo_valid toggling 1,0,0,1,1,0,1 → ofifo_rd and pmem writes only on valid cycles; A_pmem=p_base+0..3 with no gaps in address sequence.
- n_kij=3, n_act=2, p_base=0 → ACC reads pmem 0,2,4 then 1,3,5. acc is high on cycles 1-3 of each 4-cycle group. done pulses once, then busy=0.
- p_base=0x3FFF, n_act=2 → pmem writes to 0x3FFF then 0x0000.
- start while busy → ignored. reset asserted mid-DRAIN → inst idle and state IDLE next cycle; a fresh start then runs a complete correct layer.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the 8x8 core layer sequencer:
// instruction bit map, idle word and sequencer states.
package core_pkg;

   localparam int INST_W  = 50;

   localparam int B_ACC   = 49;
   localparam int B_CENP  = 48;
   localparam int B_WENP  = 47;
   localparam int B_AP_HI = 46;
   localparam int B_AP_LO = 33;
   localparam int B_CEN1  = 32;
   localparam int B_A1_HI = 31;
   localparam int B_A1_LO = 21;
   localparam int B_CEN0  = 20;
   localparam int B_WEN0  = 19;
   localparam int B_A0_HI = 18;
   localparam int B_A0_LO = 8;
   localparam int B_OFRD  = 7;
   localparam int B_IFWR  = 6;
   localparam int B_IFRD  = 5;
   localparam int B_L0RD  = 4;
   localparam int B_L0WR  = 3;
   localparam int B_MODE  = 2;
   localparam int B_EXEC  = 1;
   localparam int B_LOAD  = 0;

   // All memory enables/write-enables deasserted, everything else zero.
   localparam logic [INST_W-1:0] INST_IDLE = 50'h1_8001_0018_0000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_W_L0,
      ST_W_PE,
      ST_W_FLUSH,
      ST_X_L0,
      ST_X_EXEC,
      ST_DRAIN,
      ST_ACC,
      ST_DONE
   } state_t;

endpackage

// File: rtl/core_seq_rd_strobe_dly.sv
// One-cycle delay from a memory read request to the
// strobe that consumes the read data.
module rd_strobe_dly (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_rd,
   output logic o_stb
);

   logic r_stb;

   // Read data is valid one cycle after the request.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_stb <= 1'b0;
      else         r_stb <= i_rd;
   end

   assign o_stb = r_stb;

endmodule

// File: rtl/core_seq.sv
// Autonomous layer sequencer: weight load, activation
// stream, psum drain per kernel position, then pmem accumulate.
module core_seq
   import core_pkg::*;
#(
   parameter int ROW     = 8,
   parameter int COL     = 8,
   parameter int XMEM_AW = 11,
   parameter int PMEM_AW = 14,
   parameter int N_ACT   = 36,
   parameter int N_KIJ   = 9
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_mode,
   input  logic [XMEM_AW-1:0] i_w_base,
   input  logic [XMEM_AW-1:0] i_x_base,
   input  logic [PMEM_AW-1:0] i_p_base,
   input  logic               i_ofifo_valid,
   output logic [INST_W-1:0]  o_inst,
   output logic               o_busy,
   output logic               o_done
);

   localparam int M1   = (ROW + COL > N_ACT + 1) ? ROW + COL : N_ACT + 1;
   localparam int CMAX = (M1 > N_KIJ + 1) ? M1 : N_KIJ + 1;
   localparam int CW   = $clog2(CMAX);
   localparam int JW   = $clog2(N_ACT + 1);
   localparam int KW   = (N_KIJ > 1) ? $clog2(N_KIJ) : 1;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic [KW-1:0]      r_k;
   logic [JW-1:0]      r_j;
   logic               r_mode;
   logic [XMEM_AW-1:0] r_wb;
   logic [XMEM_AW-1:0] r_xb;
   logic [PMEM_AW-1:0] r_pb;
   logic [INST_W-1:0]  r_inst;
   logic               r_busy;
   logic               r_done;

   state_t             w_state_nx;
   logic [CW-1:0]      w_cnt_nx;
   logic [KW-1:0]      w_k_nx;
   logic [JW-1:0]      w_j_nx;
   logic [JW-1:0]      w_wr_j;
   logic               w_wr;
   logic               w_start;
   logic               w_mode_nx;
   logic [XMEM_AW-1:0] w_wb_nx;
   logic [XMEM_AW-1:0] w_xb_nx;
   logic [PMEM_AW-1:0] w_pb_nx;
   logic [XMEM_AW-1:0] w_xa;
   logic [PMEM_AW-1:0] w_pa;
   logic [INST_W-1:0]  w_inst_nx;
   logic               w_xrd;
   logic               w_prd;
   logic               w_l0_stb;
   logic               w_acc_stb;

   // Next phase/counter values for the cycle about to be issued.
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + 1'b1;
      w_k_nx     = r_k;
      w_j_nx     = r_j;
      w_start    = 1'b0;
      w_wr       = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            w_cnt_nx = '0;
            if (i_start) begin
               w_start    = 1'b1;
               w_state_nx = ST_W_L0;
               w_k_nx     = '0;
               w_j_nx     = '0;
            end
         end
         ST_W_L0:
            if (r_cnt == CW'(ROW)) begin
               w_state_nx = ST_W_PE;
               w_cnt_nx   = '0;
            end
         ST_W_PE:
            if (r_cnt == CW'(ROW - 1)) begin
               w_state_nx = ST_W_FLUSH;
               w_cnt_nx   = '0;
            end
         ST_W_FLUSH:
            if (r_cnt == CW'(ROW + COL - 1)) begin
               w_state_nx = ST_X_L0;
               w_cnt_nx   = '0;
            end
         ST_X_L0:
            if (r_cnt == CW'(N_ACT)) begin
               w_state_nx = ST_X_EXEC;
               w_cnt_nx   = '0;
            end
         ST_X_EXEC:
            if (r_cnt == CW'(N_ACT - 1)) begin
               w_state_nx = ST_DRAIN;
               w_cnt_nx   = '0;
               w_j_nx     = '0;
            end
         ST_DRAIN: begin
            w_cnt_nx = '0;
            if (r_j == JW'(N_ACT)) begin
               w_j_nx = '0;
               if (r_k == KW'(N_KIJ - 1)) begin
                  w_state_nx = ST_ACC;
               end else begin
                  w_state_nx = ST_W_L0;
                  w_k_nx     = r_k + 1'b1;
               end
            end
         end
         ST_ACC:
            if (r_cnt == CW'(N_KIJ)) begin
               w_cnt_nx = '0;
               if (r_j == JW'(N_ACT - 1)) w_state_nx = ST_DONE;
               else                       w_j_nx     = r_j + 1'b1;
            end
         ST_DONE: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
         end
         default: begin
            w_state_nx = ST_IDLE;
            w_cnt_nx   = '0;
         end
      endcase
      w_wr_j = w_j_nx;
      if (w_state_nx == ST_DRAIN && i_ofifo_valid) begin
         w_wr   = 1'b1;
         w_j_nx = w_j_nx + 1'b1;
      end
   end

   // Layer parameters are taken from the ports only on the accepting edge.
   assign w_mode_nx = w_start ? i_mode   : r_mode;
   assign w_wb_nx   = w_start ? i_w_base : r_wb;
   assign w_xb_nx   = w_start ? i_x_base : r_xb;
   assign w_pb_nx   = w_start ? i_p_base : r_pb;

   assign w_xa = XMEM_AW'((w_state_nx == ST_X_L0)
      ? int'(w_xb_nx) + int'(w_k_nx) * N_ACT + int'(w_cnt_nx)
      : int'(w_wb_nx) + int'(w_k_nx) * ROW + int'(w_cnt_nx));

   assign w_pa = PMEM_AW'((w_state_nx == ST_ACC)
      ? int'(w_pb_nx) + int'(w_cnt_nx) * N_ACT + int'(w_j_nx)
      : int'(w_pb_nx) + int'(w_k_nx) * N_ACT + int'(w_wr_j));

   // Instruction word for the upcoming cycle (strobes added later).
   always_comb begin
      w_inst_nx         = INST_IDLE;
      w_inst_nx[B_MODE] = w_mode_nx;
      unique case (w_state_nx)
         ST_W_L0:
            if (w_cnt_nx != CW'(ROW)) begin
               w_inst_nx[B_CEN0]          = 1'b0;
               w_inst_nx[B_A0_HI:B_A0_LO] = w_xa;
            end
         ST_X_L0:
            if (w_cnt_nx != CW'(N_ACT)) begin
               w_inst_nx[B_CEN0]          = 1'b0;
               w_inst_nx[B_A0_HI:B_A0_LO] = w_xa;
            end
         ST_W_PE: begin
            w_inst_nx[B_L0RD] = 1'b1;
            w_inst_nx[B_LOAD] = 1'b1;
         end
         ST_X_EXEC: begin
            w_inst_nx[B_L0RD] = 1'b1;
            w_inst_nx[B_EXEC] = 1'b1;
         end
         ST_DRAIN:
            if (w_wr) begin
               w_inst_nx[B_OFRD]          = 1'b1;
               w_inst_nx[B_CENP]          = 1'b0;
               w_inst_nx[B_WENP]          = 1'b0;
               w_inst_nx[B_AP_HI:B_AP_LO] = w_pa;
            end
         ST_ACC:
            if (w_cnt_nx != CW'(N_KIJ)) begin
               w_inst_nx[B_CENP]          = 1'b0;
               w_inst_nx[B_AP_HI:B_AP_LO] = w_pa;
            end
         default: ;
      endcase
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_k     <= '0;
         r_j     <= '0;
         r_mode  <= 1'b0;
         r_wb    <= '0;
         r_xb    <= '0;
         r_pb    <= '0;
         r_inst  <= INST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_k     <= w_k_nx;
         r_j     <= w_j_nx;
         r_mode  <= w_mode_nx;
         r_wb    <= w_wb_nx;
         r_xb    <= w_xb_nx;
         r_pb    <= w_pb_nx;
         r_inst  <= w_inst_nx;
         r_busy  <= (w_state_nx != ST_IDLE);
         r_done  <= (w_state_nx == ST_DONE);
      end
   end

   assign w_xrd = ~r_inst[B_CEN0] & r_inst[B_WEN0];
   assign w_prd = ~r_inst[B_CENP] & r_inst[B_WENP];

   rd_strobe_dly u_l0_wr (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_rd    (w_xrd),
      .o_stb   (w_l0_stb)
   );

   rd_strobe_dly u_acc (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_rd    (w_prd),
      .o_stb   (w_acc_stb)
   );

   // Merge the delayed read strobes into the issued word.
   always_comb begin
      o_inst         = r_inst;
      o_inst[B_L0WR] = r_inst[B_L0WR] | w_l0_stb;
      o_inst[B_ACC]  = r_inst[B_ACC] | w_acc_stb;
   end

   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq: two small layer shapes,
// full-trace checks on one, pmem address/strobe checks on the other.
module tb_core_seq;

   localparam logic [49:0] IDLE = 50'h1_8001_0018_0000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_start, a_mode, a_valid;
   logic [10:0] a_wb, a_xb;
   logic [13:0] a_pb;
   logic [49:0] a_inst;
   logic        a_busy, a_done;
   logic        b_start, b_mode, b_valid;
   logic [10:0] b_wb, b_xb;
   logic [13:0] b_pb;
   logic [49:0] b_inst;
   logic        b_busy, b_done;

   core_seq #(
      .ROW(8), .COL(8), .XMEM_AW(11), .PMEM_AW(14),
      .N_ACT(4), .N_KIJ(1)
   ) u_a (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_start       (a_start),
      .i_mode        (a_mode),
      .i_w_base      (a_wb),
      .i_x_base      (a_xb),
      .i_p_base      (a_pb),
      .i_ofifo_valid (a_valid),
      .o_inst        (a_inst),
      .o_busy        (a_busy),
      .o_done        (a_done)
   );

   core_seq #(
      .ROW(8), .COL(8), .XMEM_AW(11), .PMEM_AW(14),
      .N_ACT(2), .N_KIJ(3)
   ) u_b (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_start       (b_start),
      .i_mode        (b_mode),
      .i_w_base      (b_wb),
      .i_x_base      (b_xb),
      .i_p_base      (b_pb),
      .i_ofifo_valid (b_valid),
      .o_inst        (b_inst),
      .o_busy        (b_busy),
      .o_done        (b_done)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   logic [49:0] ea [0:60];
   logic [13:0] ew_b [6];
   logic [13:0] er_b [6];

   task automatic build_a;
      int widx [4];
      widx = '{43, 46, 47, 49};
      for (int i = 0; i < 61; i++) ea[i] = IDLE;
      for (int i = 0; i < 8; i++) begin
         ea[i][20]   = 1'b0;
         ea[i][18:8] = 11'h010 + 11'(i);
         ea[i+1][3]  = 1'b1;
      end
      for (int i = 9; i < 17; i++) begin
         ea[i][4] = 1'b1;
         ea[i][0] = 1'b1;
      end
      for (int i = 0; i < 4; i++) begin
         ea[33+i][20]   = 1'b0;
         ea[33+i][18:8] = 11'h040 + 11'(i);
         ea[34+i][3]    = 1'b1;
      end
      for (int i = 38; i < 42; i++) begin
         ea[i][4] = 1'b1;
         ea[i][1] = 1'b1;
      end
      for (int j = 0; j < 4; j++) begin
         ea[widx[j]][7]     = 1'b1;
         ea[widx[j]][48]    = 1'b0;
         ea[widx[j]][47]    = 1'b0;
         ea[widx[j]][46:33] = 14'h0100 + 14'(j);
      end
      for (int o = 0; o < 4; o++) begin
         ea[50+2*o][48]    = 1'b0;
         ea[50+2*o][46:33] = 14'h0100 + 14'(o);
         ea[51+2*o][49]    = 1'b1;
      end
   endtask

   task automatic run_a(input string tag);
      int vpat [7];
      vpat = '{1, 0, 0, 1, 1, 0, 1};
      a_wb = 11'h010; a_xb = 11'h040; a_pb = 14'h0100;
      a_mode = 1'b0; a_valid = 1'b0;
      a_start = 1'b1;
      step;
      a_start = 1'b0;
      for (int i = 0; i <= 60; i++) begin
         check($sformatf("%s.inst[%0d]", tag, i), 64'(a_inst), 64'(ea[i]));
         check($sformatf("%s.busy_done[%0d]", tag, i),
               {62'b0, a_busy, a_done}, {62'b0, i <= 58, i == 58});
         if (i == 0) begin
            a_wb = 11'h555; a_xb = 11'h2AA; a_pb = 14'h3333; a_mode = 1'b1;
         end
         a_valid = (i >= 42 && i <= 48) ? (vpat[i-42] != 0) : 1'b0;
         a_start = (i == 20 || i == 58);
         step;
      end
      a_start = 1'b0;
   endtask

   task automatic run_b(input string tag, input logic [13:0] pb,
                        input logic md);
      logic [13:0] wq [$];
      logic [13:0] rq [$];
      logic [1:0]  pat [$];
      int ndone = 0;
      bit fin = 1'b0;
      bit in_acc = 1'b0;
      b_wb = 11'h000; b_xb = 11'h100; b_pb = pb; b_mode = md; b_valid = 1'b1;
      b_start = 1'b1;
      step;
      b_start = 1'b0;
      b_pb = 14'h1234; b_mode = ~md;
      check({tag, ".mode"}, 64'(b_inst[2]), 64'(md));
      for (int c = 0; c < 400 && !fin; c++) begin
         if (!b_inst[48] && !b_inst[47]) begin
            wq.push_back(b_inst[46:33]);
            check({tag, ".ofrd"}, 64'(b_inst[7]), 64'd1);
         end
         if (!b_inst[48] && b_inst[47]) begin
            rq.push_back(b_inst[46:33]);
            in_acc = 1'b1;
         end
         if (in_acc && pat.size() < 8)
            pat.push_back({b_inst[49], ~b_inst[48] & b_inst[47]});
         if (b_done) ndone++;
         if (ndone > 0 && !b_busy) fin = 1'b1;
         step;
      end
      check({tag, ".finished"}, 64'(fin), 64'd1);
      check({tag, ".done_pulses"}, 64'(ndone), 64'd1);
      check({tag, ".n_wr"}, 64'(wq.size()), 64'd6);
      check({tag, ".n_rd"}, 64'(rq.size()), 64'd6);
      check({tag, ".n_pat"}, 64'(pat.size()), 64'd8);
      for (int i = 0; i < 6 && i < wq.size(); i++)
         check($sformatf("%s.wr[%0d]", tag, i), 64'(wq[i]), 64'(ew_b[i]));
      for (int i = 0; i < 6 && i < rq.size(); i++)
         check($sformatf("%s.rd[%0d]", tag, i), 64'(rq[i]), 64'(er_b[i]));
      for (int c = 0; c < pat.size(); c++)
         check($sformatf("%s.acc_rd[%0d]", tag, c), 64'(pat[c]),
               {62'b0, (c % 4) != 0, (c % 4) < 3});
      b_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      a_start = 1'b0; a_mode = 1'b0; a_valid = 1'b0;
      a_wb = '0; a_xb = '0; a_pb = '0;
      b_start = 1'b0; b_mode = 1'b0; b_valid = 1'b0;
      b_wb = '0; b_xb = '0; b_pb = '0;
      step;
      step;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         check("reset_idle_a", {12'b0, a_inst, a_busy, a_done}, {12'b0, IDLE, 2'b00});
         check("reset_idle_b", {12'b0, b_inst, b_busy, b_done}, {12'b0, IDLE, 2'b00});
         step;
      end

      build_a;
      run_a("A1");

      ew_b = '{14'h0000, 14'h0001, 14'h0002, 14'h0003, 14'h0004, 14'h0005};
      er_b = '{14'h0000, 14'h0002, 14'h0004, 14'h0001, 14'h0003, 14'h0005};
      run_b("B1", 14'h0000, 1'b0);

      ew_b = '{14'h3FFF, 14'h0000, 14'h0001, 14'h0002, 14'h0003, 14'h0004};
      er_b = '{14'h3FFF, 14'h0001, 14'h0003, 14'h0000, 14'h0002, 14'h0004};
      run_b("B2", 14'h3FFF, 1'b1);

      a_wb = 11'h010; a_xb = 11'h040; a_pb = 14'h0100;
      a_mode = 1'b0; a_valid = 1'b0;
      a_start = 1'b1;
      step;
      a_start = 1'b0;
      repeat (42) step;
      a_valid = 1'b1;
      step;
      step;
      check("A.mid_drain_wr", 64'(a_inst[7]), 64'd1);
      check("A.mid_drain_addr", 64'(a_inst[46:33]), 64'h0101);
      rst = 1'b1;
      step;
      check("A.rst_inst", 64'(a_inst), 64'(IDLE));
      check("A.rst_busy", 64'(a_busy), 64'd0);
      check("A.rst_done", 64'(a_done), 64'd0);
      rst = 1'b0;
      a_valid = 1'b0;
      step;
      check("A.post_rst", {13'b0, a_inst, a_busy}, {13'b0, IDLE, 1'b0});

      run_a("A2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
